// File: rtl/csc_stream_ctrl.sv
// -----------------------------------------------------------------------------
// csc_stream_ctrl
//
// Front end for an external YCbCr->RGB colour-space converter. Takes a 4:2:2
// byte stream (Cb,Y0,Cr,Y1), splits every quad into two pixels that share the
// quad's chroma, and hands each pixel to the converter as a registered operand
// triple. A tag (valid, line start, frame start) for every pixel travels down a
// CSC_LAT-deep delay line that matches the converter's latency, so the result
// comes back lined up with its markers and is registered as the output pixel.
// pix_x / pix_y are worked out on the output side from those markers.
//
// Parameters
//   CSC_LAT   cycles from csc_y/cb/cr changing to csc_r/g/b holding the result
//   LINE_MAX  pixels per line; pix_x saturates at LINE_MAX-1
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   din, din_de, din_vs      byte stream, active-video qualifier, vsync
//   csc_y, csc_cb, csc_cr    registered operands to the converter
//   csc_r, csc_g, csc_b      converter results
//   pix_rgb, pix_valid       registered {r,g,b} and its qualifier
//   pix_sol, pix_sof         first pixel of line / frame (only with pix_valid)
//   pix_x, pix_y             coordinates of the pixel on pix_rgb
//   err_quad, err_clr        sticky incomplete-quad flag and its clear
// -----------------------------------------------------------------------------
module csc_stream_ctrl #(
  parameter int CSC_LAT  = 1,
  parameter int LINE_MAX = 720
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_de,
  input  logic        din_vs,
  output logic [7:0]  csc_y,
  output logic [7:0]  csc_cb,
  output logic [7:0]  csc_cr,
  input  logic [7:0]  csc_r,
  input  logic [7:0]  csc_g,
  input  logic [7:0]  csc_b,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  output logic        pix_sol,
  output logic        pix_sof,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        err_quad,
  input  logic        err_clr
);

  localparam logic [10:0] X_LAST = 11'(LINE_MAX - 1);

  typedef enum logic [1:0] {S_CB, S_Y0, S_CR, S_Y1} phase_e;

  // Per-pixel tag carried alongside the converter latency.
  typedef struct packed {
    logic vld;
    logic sol;
    logic sof;
  } tag_t;

  phase_e     phase;
  phase_e     cur_phase;
  logic       de_q;
  logic       vs_q;
  logic       de_rise;
  logic       de_fall;
  logic       vs_rise;
  logic [7:0] cb_q;
  logic [7:0] y0_q;
  logic [7:0] cr_q;
  logic       sol_pend;
  logic       sof_pend;
  tag_t       issue;
  tag_t       dly [CSC_LAT];
  tag_t       dly_out;

  // ---------------------------------------------------------------------------
  // Edge detection and the phase the current byte belongs to. A rise of din_de
  // or din_vs restarts the quad, so the byte arriving with it is always Cb.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a value before any condition, so no path
    // leaves one unassigned and no latch is inferred.
    de_rise   = din_de & ~de_q;
    de_fall   = ~din_de & de_q;
    vs_rise   = din_vs & ~vs_q;
    cur_phase = phase;
    if (de_rise || vs_rise) begin
      cur_phase = S_CB;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase FSM: byte capture, operand issue, marker arming and error flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    if (!rst_n) begin
      phase    <= S_CB;
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      cb_q     <= '0;
      y0_q     <= '0;
      cr_q     <= '0;
      csc_y    <= '0;
      csc_cb   <= '0;
      csc_cr   <= '0;
      sol_pend <= 1'b0;
      sof_pend <= 1'b0;
      issue    <= '0;
      err_quad <= 1'b0;
    end else begin
      de_q  <= din_de;
      vs_q  <= din_vs;
      issue <= '0;

      // Arm the markers for the next pixel issued. An issue can never happen
      // on the same edge as a rise (a rise forces S_CB), so the clears below
      // never fight these sets.
      if (vs_rise) begin
        sol_pend <= 1'b1;
        sof_pend <= 1'b1;
      end else if (de_rise) begin
        sol_pend <= 1'b1;
      end

      if (din_de) begin
        unique case (cur_phase)
          S_CB: begin
            cb_q  <= din;
            phase <= S_Y0;
          end
          S_Y0: begin
            y0_q  <= din;
            phase <= S_CR;
          end
          S_CR: begin
            cr_q     <= din;
            csc_y    <= y0_q;
            csc_cb   <= cb_q;
            csc_cr   <= din;
            issue    <= '{vld: 1'b1, sol: sol_pend, sof: sof_pend};
            sol_pend <= 1'b0;
            sof_pend <= 1'b0;
            phase    <= S_Y1;
          end
          S_Y1: begin
            csc_y    <= din;
            csc_cb   <= cb_q;
            csc_cr   <= cr_q;
            issue    <= '{vld: 1'b1, sol: sol_pend, sof: sof_pend};
            sol_pend <= 1'b0;
            sof_pend <= 1'b0;
            phase    <= S_CB;
          end
        endcase
      end else begin
        // Idle bytes are dropped; a vsync rise still re-arms the phase.
        phase <= cur_phase;
      end

      // phase is the next byte expected, so anything but S_CB at a falling
      // din_de means the quad was cut short. Setting wins over clearing.
      if (de_fall && (phase != S_CB)) begin
        err_quad <= 1'b1;
      end else if (err_clr) begin
        err_quad <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag delay line, CSC_LAT stages deep, matching the converter latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the delay line is a register array and is reset on purpose: a
    // stale valid bit surviving reset would emit a phantom pixel.
    if (!rst_n) begin
      for (int i = 0; i < CSC_LAT; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= issue;
      for (int i = 1; i < CSC_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign dly_out = dly[CSC_LAT-1];

  // ---------------------------------------------------------------------------
  // Output register: capture the converter result and derive coordinates from
  // the markers that travelled with it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rgb   <= '0;
      pix_valid <= 1'b0;
      pix_sol   <= 1'b0;
      pix_sof   <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_valid <= dly_out.vld;
      pix_sol   <= dly_out.vld & dly_out.sol;
      pix_sof   <= dly_out.vld & dly_out.sof;
      if (dly_out.vld) begin
        pix_rgb <= {csc_r, csc_g, csc_b};
        if (dly_out.sol) begin
          pix_x <= '0;
          // pix_y wraps 1023 -> 0 through its natural 10-bit width.
          pix_y <= dly_out.sof ? '0 : pix_y + 10'd1;
        end else if (pix_x != X_LAST) begin
          pix_x <= pix_x + 11'd1;
        end
      end
    end
  end

endmodule
